uart_rx_core: RTL

Synchronous UART receiver: the inbound counterpart to the transmit path of the `tt03` SpinalHDL UART. It oversamples the asynchronous `io_rxd` pin against a programmable baud tick and recovers frames with majority-vote bit sampling. Each byte is delivered on a valid/ready handshake, with per-frame parity, framing and break status and a sticky overrun flag. It sits beside the transmitter inside the UART core, downstream of `async_reset_ctrl`, and is driven by the same `clk` and `reset`.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_core.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, defaults and helpers
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DIV_WIDTH  = 12;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - programmable sample-tick divider
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] io_divisor,
  input  logic                 io_restart,
  output logic                 io_tick
);

  logic [DIV_WIDTH-1:0] cnt;

  // Divisor is only picked up on reload, so a change never truncates a running period.
  always_ff @(posedge clk) begin
    if (reset || io_restart) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= io_divisor;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign io_tick = (cnt == '0);

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling UART receiver with majority-vote sampling
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] io_divisor,
  input  logic                 io_parityEnable,
  input  logic                 io_parityOdd,
  input  logic                 io_stopBits2,
  input  logic                 io_rxd,
  output logic [DATA_BITS-1:0] io_data,
  output logic                 io_valid,
  input  logic                 io_ready,
  output logic                 io_frameError,
  output logic                 io_parityError,
  output logic                 io_breakDetect,
  output logic                 io_overrun,
  input  logic                 io_errorClear
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [PW-1:0] PH_S0    = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_S1    = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_S2    = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0] PH_END   = PW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_e state, state_n;

  logic                 sync1, rxs, rxs_q;
  logic                 tick, fall, start_edge;
  logic [PW-1:0]        phase;
  logic                 s0, s1, maj;
  logic                 mid_done, bit_end, last_stop, commit;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] data_sr;
  logic                 par_err, ferr, stop1_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      sync1 <= io_rxd;
      rxs   <= sync1;
      rxs_q <= rxs;
    end
  end

  assign fall       = rxs_q & ~rxs;
  assign start_edge = (state == RX_IDLE) && fall;

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud_tick (
    .clk        (clk),
    .reset      (reset),
    .io_divisor (io_divisor),
    .io_restart (start_edge),
    .io_tick    (tick)
  );

  // The vote completes on the third sample; that tick is where each bit is decided.
  assign maj       = majority3(s0, s1, rxs);
  assign mid_done  = tick && (phase == PH_S2);
  assign bit_end   = tick && (phase == PH_END);
  assign last_stop = (stop_idx == io_stopBits2);
  assign commit    = (state == RX_STOP) && mid_done && last_stop;

  always_ff @(posedge clk) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      RX_IDLE:   if (fall) state_n = RX_START;
      RX_START: begin
        if (mid_done && maj) state_n = RX_IDLE;
        else if (bit_end)    state_n = RX_DATA;
      end
      RX_DATA:   if (bit_end && (bit_idx == LAST_BIT)) state_n = io_parityEnable ? RX_PARITY : RX_STOP;
      RX_PARITY: if (bit_end) state_n = RX_STOP;
      RX_STOP:   if (commit) state_n = RX_IDLE;
      default:   state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      data_sr    <= '0;
      par_err    <= 1'b0;
      ferr       <= 1'b0;
      stop1_zero <= 1'b0;
    end else if (start_edge) begin
      phase      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      data_sr    <= '0;
      par_err    <= 1'b0;
      ferr       <= 1'b0;
      stop1_zero <= 1'b0;
    end else if ((state != RX_IDLE) && tick) begin
      phase <= (phase == PH_END) ? '0 : phase + 1'b1;
      if (phase == PH_S0) s0 <= rxs;
      if (phase == PH_S1) s1 <= rxs;
      if (phase == PH_S2) begin
        case (state)
          RX_DATA:   data_sr[bit_idx] <= maj;
          RX_PARITY: par_err <= ((^data_sr) ^ maj) != io_parityOdd;
          RX_STOP: begin
            if (!maj) ferr <= 1'b1;
            if (stop_idx == 1'b0) stop1_zero <= ~maj;
          end
          default: ;
        endcase
      end
      if (phase == PH_END) begin
        if (state == RX_DATA) bit_idx  <= bit_idx + 1'b1;
        if (state == RX_STOP) stop_idx <= 1'b1;
      end
    end
  end

  // A commit into a full holding register is dropped, leaving the old byte intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_valid       <= 1'b0;
      io_data        <= '0;
      io_frameError  <= 1'b0;
      io_parityError <= 1'b0;
      io_breakDetect <= 1'b0;
      io_overrun     <= 1'b0;
    end else begin
      if (commit && (!io_valid || io_ready)) begin
        io_valid       <= 1'b1;
        io_data        <= data_sr;
        io_frameError  <= ferr | ~maj;
        io_parityError <= par_err;
        io_breakDetect <= (data_sr == '0) && ((stop_idx == 1'b0) ? ~maj : stop1_zero);
      end else if (io_valid && io_ready) begin
        io_valid <= 1'b0;
      end
      if (commit && io_valid && !io_ready) io_overrun <= 1'b1;
      else if (io_errorClear)              io_overrun <= 1'b0;
    end
  end

endmodule
